// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM state encoding,
// default reset vector and the sequential-fetch increment.
package inst_fetch_pkg;

    // Fetch FSM states. At most one memory request is outstanding at any time.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,   // presenting a request, waiting for grant
        ST_WAIT = 2'd1,   // request granted, waiting for response data
        ST_HOLD = 2'd2    // instruction held for the consumer
    } fetch_state_t;

    // Default fetch address after reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // Byte distance between consecutive instructions.
    localparam int unsigned ILEN = 4;

endpackage : inst_fetch_pkg

// File: rtl/inst_fetch_pc_reg.sv
// Fetch program counter: holds the address of the next instruction to
// request and selects between reset vector, redirect target and the
// sequential increment. Redirect always wins over the increment.
module ifu_pc_reg
    import inst_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_advance,
    input  logic [XLEN-1:0] i_advance_base,
    output logic [XLEN-1:0] o_pc
);

    // Instructions are word aligned, so the two low bits of any target are
    // cleared. The increment wraps naturally modulo 2^XLEN.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(2'b11));
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(ILEN);

    logic [XLEN-1:0] r_pc;

    // Fetch PC register: reset vector, then redirect or sequential advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_pc <= i_redirect_pc & ALIGN_MASK;
        end else if (i_advance) begin
            r_pc <= i_advance_base + PC_STEP;
        end else begin
            r_pc <= r_pc;
        end
    end

    assign o_pc = r_pc;

endmodule : ifu_pc_reg

// File: rtl/inst_fetch.sv
// Instruction fetch unit. Issues one word request at a time to instruction
// memory, captures the response and hands it to the decode/execute stage
// with a valid/ready handshake. Redirects from execute override everything;
// a response belonging to a request made before the redirect is dropped.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    // instruction memory request/response
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    // consumer side
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc,
    // control-flow redirect from execute
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic            r_drop;
    logic            w_drop_nxt;
    logic            r_if_valid;
    logic            w_if_valid_nxt;
    logic [XLEN-1:0] r_if_inst;
    logic [XLEN-1:0] r_if_pc;
    logic            w_load_resp;
    logic            w_advance;
    logic [XLEN-1:0] w_fetch_pc;

    ifu_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst            (rst),
        .i_redirect     (redirect_valid),
        .i_redirect_pc  (redirect_pc),
        .i_advance      (w_advance),
        .i_advance_base (r_if_pc),
        .o_pc           (w_fetch_pc)
    );

    // Next-state logic: redirect first, then the normal handshake events.
    always_comb begin
        w_state_nxt    = r_state;
        w_drop_nxt     = r_drop;
        w_if_valid_nxt = r_if_valid;
        w_load_resp    = 1'b0;
        w_advance      = 1'b0;
        case (r_state)
            ST_REQ: begin
                if (imem_gnt) begin
                    // A grant together with a redirect still launches the old
                    // address, so its response must be thrown away later.
                    w_state_nxt = ST_WAIT;
                    w_drop_nxt  = redirect_valid;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_valid || r_drop) begin
                        w_state_nxt = ST_REQ;
                        w_drop_nxt  = 1'b0;
                    end else begin
                        w_load_resp    = 1'b1;
                        w_if_valid_nxt = 1'b1;
                        w_state_nxt    = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    w_drop_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    w_if_valid_nxt = 1'b0;
                    w_state_nxt    = ST_REQ;
                end else if (if_ready) begin
                    w_advance      = 1'b1;
                    w_if_valid_nxt = 1'b0;
                    w_state_nxt    = ST_REQ;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt    = ST_REQ;
                w_drop_nxt     = 1'b0;
                w_if_valid_nxt = 1'b0;
            end
        endcase
    end

    // Control state registers: FSM state, drop flag and output valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_REQ;
            r_drop     <= 1'b0;
            r_if_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_drop     <= w_drop_nxt;
            r_if_valid <= w_if_valid_nxt;
        end
    end

    // Instruction/PC capture register, loaded only by a kept response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_inst <= '0;
            r_if_pc   <= '0;
        end else if (w_load_resp) begin
            r_if_inst <= imem_rdata;
            r_if_pc   <= w_fetch_pc;
        end else begin
            r_if_inst <= r_if_inst;
            r_if_pc   <= r_if_pc;
        end
    end

    // The request is gated by rst so that it is low during reset yet rises
    // in the very first cycle after reset is released.
    assign imem_req  = (r_state == ST_REQ) && !rst;
    assign imem_addr = w_fetch_pc;
    assign if_valid  = r_if_valid;
    assign if_inst   = r_if_inst;
    assign if_pc     = r_if_pc;

endmodule : inst_fetch

// File: tb/tb_inst_fetch.sv
// Directed, table-driven bench for inst_fetch. Each vector is one clock
// cycle: inputs are driven after the falling edge and outputs are compared
// 1 time unit later, i.e. they reflect state from the previous rising edge.
module tb_inst_fetch;

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] redir_pc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int errors = 0;
    int checks = 0;
    int vec_no = 0;

    inst_fetch #(
        .XLEN     (32),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic g, input logic rv,
                                input logic [31:0] rd, input logic rdy,
                                input logic rdr, input logic [31:0] rdpc,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic ev, input logic [31:0] einst,
                                input logic [31:0] epc);
        vec_t v;
        v.rst = r; v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy;
        v.redir = rdr; v.redir_pc = rdpc;
        v.e_req = ereq; v.e_addr = eaddr; v.e_valid = ev;
        v.e_inst = einst; v.e_pc = epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec %0d %s: got %h expected %h", vec_no, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst            = v.rst;
        imem_gnt       = v.gnt;
        imem_rvalid    = v.rvalid;
        imem_rdata     = v.rdata;
        if_ready       = v.ready;
        redirect_valid = v.redir;
        redirect_pc    = v.redir_pc;
        #1;
        chk("imem_req",  {31'd0, imem_req}, {31'd0, v.e_req});
        chk("imem_addr", imem_addr, v.e_addr);
        chk("if_valid",  {31'd0, if_valid}, {31'd0, v.e_valid});
        chk("if_inst",   if_inst, v.e_inst);
        chk("if_pc",     if_pc, v.e_pc);
        vec_no++;
    endtask

    localparam logic [31:0] RV = 32'h8000_0000;
    localparam logic [31:0] Z  = 32'h0000_0000;

    vec_t tbl[$];

    initial begin
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        repeat (2) @(posedge clk);

        // Reset, basic fetch, stalled grant, stalled consumer, redirect in WAIT.
        //            rst   gnt   rv    rdata         rdy   rdr   rdpc          req   addr          v     inst          pc
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, Z,           1'b0, 1'b0, Z,           1'b0, RV,           1'b0, Z,           Z));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, Z,           1'b0, 1'b0, Z,           1'b1, RV,           1'b0, Z,           Z));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h00100093,1'b0, 1'b0, Z,           1'b0, RV,           1'b0, Z,           Z));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, Z,           1'b1, 1'b0, Z,           1'b0, RV,           1'b1, 32'h00100093,RV));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1'b0, 1'b0, 1'b0, Z,       1'b0, 1'b0, Z,           1'b1, 32'h80000004, 1'b0, 32'h00100093,RV));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, Z,           1'b0, 1'b0, Z,           1'b1, 32'h80000004, 1'b0, 32'h00100093,RV));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h00000013,1'b0, 1'b0, Z,           1'b0, 32'h80000004, 1'b0, 32'h00100093,RV));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b0, 1'b0, 1'b0, Z,       1'b0, 1'b0, Z,           1'b0, 32'h80000004, 1'b1, 32'h00000013,32'h80000004));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, Z,           1'b1, 1'b0, Z,           1'b0, 32'h80000004, 1'b1, 32'h00000013,32'h80000004));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, Z,           1'b0, 1'b0, Z,           1'b1, 32'h80000008, 1'b0, 32'h00000013,32'h80000004));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, Z,           1'b0, 1'b1, 32'h80000100,1'b0, 32'h80000008, 1'b0, 32'h00000013,32'h80000004));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'hDEADBEEF,1'b0, 1'b0, Z,           1'b0, 32'h80000100, 1'b0, 32'h00000013,32'h80000004));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, Z,           1'b0, 1'b0, Z,           1'b1, 32'h80000100, 1'b0, 32'h00000013,32'h80000004));
        foreach (tbl[i]) apply(tbl[i]);

        // Redirect to an unaligned target in the same cycle the consumer accepts.
        apply(mk(1'b0, 1'b1, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, 32'h80000100, 1'b0, 32'h00000013, 32'h80000004));
        apply(mk(1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0, Z,            1'b0, 32'h80000100, 1'b0, 32'h00000013, 32'h80000004));
        apply(mk(1'b0, 1'b0, 1'b0, Z,            1'b1, 1'b1, 32'h80000203, 1'b0, 32'h80000100, 1'b1, 32'h11111111, 32'h80000100));
        apply(mk(1'b0, 1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, 32'h80000200, 1'b0, 32'h11111111, 32'h80000100));

        // Redirect in REQ without grant, then wrap of the PC at the top of memory.
        apply(mk(1'b0, 1'b0, 1'b0, Z,            1'b0, 1'b1, 32'hFFFFFFFE, 1'b1, 32'h80000200, 1'b0, 32'h11111111, 32'h80000100));
        apply(mk(1'b0, 1'b1, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, 32'hFFFFFFFC, 1'b0, 32'h11111111, 32'h80000100));
        apply(mk(1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0, Z,            1'b0, 32'hFFFFFFFC, 1'b0, 32'h11111111, 32'h80000100));
        apply(mk(1'b0, 1'b0, 1'b0, Z,            1'b1, 1'b0, Z,            1'b0, 32'hFFFFFFFC, 1'b1, 32'h22222222, 32'hFFFFFFFC));
        apply(mk(1'b0, 1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, 32'h00000000, 1'b0, 32'h22222222, 32'hFFFFFFFC));

        // Stray rvalid in REQ; redirect with grant; redirect with rvalid; redirect in HOLD.
        apply(mk(1'b0, 1'b0, 1'b1, 32'h33333333, 1'b0, 1'b0, Z,            1'b1, 32'h00000000, 1'b0, 32'h22222222, 32'hFFFFFFFC));
        apply(mk(1'b0, 1'b1, 1'b0, Z,            1'b0, 1'b1, 32'h80000300, 1'b1, 32'h00000000, 1'b0, 32'h22222222, 32'hFFFFFFFC));
        apply(mk(1'b0, 1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, 32'h80000300, 1'b0, 32'h22222222, 32'hFFFFFFFC));
        apply(mk(1'b0, 1'b0, 1'b1, 32'h44444444, 1'b0, 1'b0, Z,            1'b0, 32'h80000300, 1'b0, 32'h22222222, 32'hFFFFFFFC));
        apply(mk(1'b0, 1'b1, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, 32'h80000300, 1'b0, 32'h22222222, 32'hFFFFFFFC));
        apply(mk(1'b0, 1'b0, 1'b1, 32'h55555555, 1'b0, 1'b1, 32'h80000400, 1'b0, 32'h80000300, 1'b0, 32'h22222222, 32'hFFFFFFFC));
        apply(mk(1'b0, 1'b1, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, 32'h80000400, 1'b0, 32'h22222222, 32'hFFFFFFFC));
        apply(mk(1'b0, 1'b0, 1'b1, 32'h66666666, 1'b0, 1'b0, Z,            1'b0, 32'h80000400, 1'b0, 32'h22222222, 32'hFFFFFFFC));
        apply(mk(1'b0, 1'b0, 1'b0, Z,            1'b0, 1'b1, 32'h80000500, 1'b0, 32'h80000400, 1'b1, 32'h66666666, 32'h80000400));
        apply(mk(1'b0, 1'b1, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, 32'h80000500, 1'b0, 32'h66666666, 32'h80000400));

        // Reset while a request is outstanding, then a clean fetch again.
        apply(mk(1'b1, 1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, 32'h80000500, 1'b0, 32'h66666666, 32'h80000400));
        apply(mk(1'b1, 1'b0, 1'b1, 32'h77777777, 1'b0, 1'b0, Z,            1'b0, RV,           1'b0, Z,            Z));
        apply(mk(1'b0, 1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, RV,           1'b0, Z,            Z));
        apply(mk(1'b0, 1'b1, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, RV,           1'b0, Z,            Z));
        apply(mk(1'b0, 1'b0, 1'b1, 32'h00100093, 1'b0, 1'b0, Z,            1'b0, RV,           1'b0, Z,            Z));
        apply(mk(1'b0, 1'b0, 1'b0, Z,            1'b1, 1'b0, Z,            1'b0, RV,           1'b1, 32'h00100093, RV));
        apply(mk(1'b0, 1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, 32'h80000004, 1'b0, 32'h00100093, RV));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_inst_fetch
